// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin byte-serial owner of the external memory port for fetch and load/store; define MEM_ARB_IO_STALL_EN to stall IO-region writes while io_buffer_full is high
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [1:0] IO_HI_BITS = 2'b11
) (
  input  logic                  clk,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ready,
  output logic [DATA_WIDTH-1:0] if_data,
  input  logic                  lsb_req,
  input  logic                  lsb_wr,
  input  logic [1:0]            lsb_size,
  input  logic [ADDR_WIDTH-1:0] lsb_addr,
  input  logic [DATA_WIDTH-1:0] lsb_wdata,
  output logic                  lsb_ready,
  output logic [DATA_WIDTH-1:0] lsb_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);
  typedef enum logic [1:0] {IDLE, IF_RD, LS_RD, LS_WR} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d, n_q, n_d, cnt_nx, lsb_n;
  logic [1:0] lane;
  logic last_lsb_q, last_lsb_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d, mem_a_q, mem_a_d, waddr;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, buf_q, buf_d, cap;
  logic [DATA_WIDTH-1:0] if_data_q, if_data_d, lsb_rdata_q, lsb_rdata_d;
  logic if_ready_q, if_ready_d, lsb_ready_q, lsb_ready_d, mem_wr_q, mem_wr_d;
  logic [7:0] mem_dout_q, mem_dout_d;
  logic if_ok, lsb_ok, grant_if, grant_ls, stall_g, stall_w;
  assign cnt_nx = cnt_q + 3'd1;
  assign lane = cnt_q[1:0] - 2'd1;
  assign lsb_n = lsb_size == 2'd0 ? 3'd1 : lsb_size == 2'd1 ? 3'd2 : 3'd4;
  assign waddr = base_q + ADDR_WIDTH'(cnt_q);
  // a requester whose ready pulse is showing still has req high, so it is masked for that edge
  assign if_ok = if_req && !flush && !if_ready_q;
  assign lsb_ok = lsb_req && !lsb_ready_q && (lsb_wr || !flush);
  assign grant_if = if_ok && (!lsb_ok || last_lsb_q);
  assign grant_ls = lsb_ok && !grant_if;
`ifdef MEM_ARB_IO_STALL_EN
  assign stall_g = lsb_addr[17:16] == IO_HI_BITS && io_buffer_full;
  assign stall_w = waddr[17:16] == IO_HI_BITS && io_buffer_full;
`else
  logic unused_io;
  assign unused_io = io_buffer_full | (|IO_HI_BITS);
  assign stall_g = 1'b0;
  assign stall_w = 1'b0;
`endif
  assign if_ready = if_ready_q;
  assign lsb_ready = lsb_ready_q;
  assign if_data = if_data_q;
  assign lsb_rdata = lsb_rdata_q;
  assign mem_a = mem_a_q;
  assign mem_dout = mem_dout_q;
  assign mem_wr = mem_wr_q;
  // read buffer with the byte arriving this edge merged into lane cnt-1
  always_comb begin
    cap = buf_q;
    cap[8*lane +: 8] = mem_din;
  end
  // arbitration, byte sequencing and output next-state
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    n_d = n_q;
    last_lsb_d = last_lsb_q;
    base_d = base_q;
    wdata_d = wdata_q;
    buf_d = buf_q;
    if_data_d = if_data_q;
    lsb_rdata_d = lsb_rdata_q;
    mem_a_d = mem_a_q;
    mem_dout_d = mem_dout_q;
    if_ready_d = 1'b0;
    lsb_ready_d = 1'b0;
    mem_wr_d = 1'b0;
    case (state_q)
      IDLE: if (grant_if || grant_ls) begin
        last_lsb_d = grant_ls;
        base_d = grant_if ? if_addr : lsb_addr;
        mem_a_d = base_d;
        n_d = grant_if ? 3'd4 : lsb_n;
        wdata_d = lsb_wdata;
        buf_d = '0;
        cnt_d = 3'd0;
        state_d = grant_if ? IF_RD : lsb_wr ? LS_WR : LS_RD;
        if (grant_ls && lsb_wr && !stall_g) begin
          mem_wr_d = 1'b1;
          mem_dout_d = lsb_wdata[7:0];
          cnt_d = 3'd1;
          if (lsb_n == 3'd1) begin
            lsb_ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IF_RD, LS_RD: if (flush) state_d = IDLE;
      else begin
        cnt_d = cnt_nx;
        if (cnt_nx < n_q) mem_a_d = base_q + ADDR_WIDTH'(cnt_nx);
        if (cnt_q != 3'd0) buf_d = cap;
        if (cnt_q == n_q) begin
          state_d = IDLE;
          if (state_q == IF_RD) begin
            if_ready_d = 1'b1;
            if_data_d = cap;
          end else begin
            lsb_ready_d = 1'b1;
            lsb_rdata_d = cap;
          end
        end
      end
      default: if (!stall_w) begin
        mem_wr_d = 1'b1;
        mem_a_d = waddr;
        mem_dout_d = wdata_q[8*cnt_q[1:0] +: 8];
        cnt_d = cnt_nx;
        if (cnt_nx == n_q) begin
          lsb_ready_d = 1'b1;
          state_d = IDLE;
        end
      end
    endcase
  end
  // state register; a low rdy_in freezes everything but drops the write strobe
  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= IDLE;
      cnt_q <= '0;
      n_q <= '0;
      last_lsb_q <= 1'b1;
      base_q <= '0;
      wdata_q <= '0;
      buf_q <= '0;
      if_data_q <= '0;
      lsb_rdata_q <= '0;
      mem_a_q <= '0;
      mem_dout_q <= '0;
      if_ready_q <= 1'b0;
      lsb_ready_q <= 1'b0;
      mem_wr_q <= 1'b0;
    end else if (rdy_in) begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      n_q <= n_d;
      last_lsb_q <= last_lsb_d;
      base_q <= base_d;
      wdata_q <= wdata_d;
      buf_q <= buf_d;
      if_data_q <= if_data_d;
      lsb_rdata_q <= lsb_rdata_d;
      mem_a_q <= mem_a_d;
      mem_dout_q <= mem_dout_d;
      if_ready_q <= if_ready_d;
      lsb_ready_q <= lsb_ready_d;
      mem_wr_q <= mem_wr_d;
    end else begin
      mem_wr_q <= 1'b0;
    end
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sole owner of the single byte-wide external memory port.
- Shares the port between the instruction-fetch path (word reads feeding the fetch/cache side) and the load/store buffer (byte, half and word loads and stores).
- Serialises every multi-byte access into per-byte memory cycles and arbitrates round-robin between the two requesters.
- Handles pipeline flush by abandoning speculative reads; committed stores always run to completion.

Parameters:
ADDR_WIDTH, 32, address width of requests and mem_a
DATA_WIDTH, 32, width of fetch/load/store data words
IO_HI_BITS, 2'b11, value of addr[17:16] that selects the memory-mapped IO region

Ports:
clk  in  1  clock, all state updates on posedge
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; low freezes all state
flush  in  1  ROB misprediction flush
if_req  in  1  fetch request, held high until if_ready
if_addr  in  ADDR_WIDTH  fetch address, stable while if_req is high
if_ready  out  1  one-cycle pulse: if_data valid
if_data  out  DATA_WIDTH  fetched word, little-endian assembled
lsb_req  in  1  load/store request, held high until lsb_ready
lsb_wr  in  1  1 = store, 0 = load
lsb_size  in  2  0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is treated as 4 bytes
lsb_addr  in  ADDR_WIDTH  access address
lsb_wdata  in  DATA_WIDTH  store data, low bytes used
lsb_ready  out  1  one-cycle pulse: load data valid, or store done
lsb_rdata  out  DATA_WIDTH  load data, zero-extended; sign extension is done by the LSB
mem_din  in  8  byte returned by memory
mem_dout  out  8  byte to write
mem_a  out  ADDR_WIDTH  byte address
mem_wr  out  1  1 = write this cycle
io_buffer_full  in  1  IO write buffer full

Behaviour:
- Reset (rst_in=1 at posedge): state=IDLE, cnt=0, last_grant=LSB. if_ready, lsb_ready, mem_wr, mem_dout, mem_a, if_data and lsb_rdata all 0. Any in-flight access is dropped.
- rdy_in=0: no register changes except mem_wr, which is forced to 0. Ready pulses are held.
- States: IDLE, IF_RD, LS_RD, LS_WR. All memory-side outputs are registered.
- IDLE arbitration at a posedge:
  - Both requests pending: grant the requester not equal to last_grant.
  - Only one pending: grant it.
  - A grant updates last_grant.
  - When flush=1 at the same edge, if_req and load requests are ignored; a store request is still granted.
- Grant actions: mem_a<=addr, cnt<=0, N = 4 (fetch) or byte count from lsb_size.
- Read (IF_RD/LS_RD):
  - mem_a steps addr, addr+1, ..., addr+N-1 on successive edges.
  - The byte addressed at edge k is sampled from mem_din at edge k+2 and written into byte lane k.
  - After the last issue, mem_a holds its value.
  - At the edge capturing byte N-1: ready pulse <=1, data <= assembled word, state <= IDLE.
  - A 4-byte read shows its ready pulse in the 6th cycle after the grant edge.
- Write (LS_WR):
  - Byte k goes out with mem_a=addr+k, mem_dout=wdata[8k+7:8k], mem_wr=1.
  - At the edge issuing byte N-1: lsb_ready<=1, state<=IDLE.
  - At the next edge: mem_wr<=0.
- Ready pulses last exactly one cycle. A requester may drop or re-raise req in the cycle after its pulse; the next grant can occur at the edge following the pulse.
- Flush while in IF_RD or LS_RD: at that edge state<=IDLE, mem_wr=0, no ready pulse. Bytes still in flight on mem_din are discarded.
- Flush while in LS_WR: ignored; the store completes.
- Flush and a final-capture edge coinciding: flush wins, no pulse.
- Address wrap: addr+k is computed modulo 2^ADDR_WIDTH.

Optional Feature:
- MEM_ARB_IO_STALL_EN defined:
  - On any write issue edge (grant or LS_WR) where addr[17:16]==IO_HI_BITS and io_buffer_full=1, no byte is issued: mem_wr<=0 and cnt holds.
  - Issue resumes on the first edge with io_buffer_full=0.
  - Reads are never stalled.
- MEM_ARB_IO_STALL_EN undefined: io_buffer_full is ignored.

Test Plan:
- Fetch: if_req=1, if_addr=0x100, memory bytes 13,05,00,00 → mem_a=0x100..0x103 on 4 consecutive cycles; if_ready one cycle with if_data=0x00000513, 6 cycles after grant.
- Store: lsb_req, lsb_wr=1, size=1, addr=0x2002, wdata=0xBEEF → mem_wr=1 for 2 cycles with (0x2002,EF), (0x2003,BE); lsb_ready pulses with the last byte; mem_wr=0 next cycle.
- Contention: if_req and lsb load size=0 raised together after reset (last_grant=LSB) → fetch granted first, then the load; if_ready precedes lsb_ready.
- Flush mid-fetch: flush=1 at cnt=2 of a fetch → state IDLE, no if_ready; a new fetch to 0x200 returns its own word only.
- Flush mid-store: flush=1 during byte 1 of a 4-byte store → all 4 bytes written, lsb_ready pulses.
- With MEM_ARB_IO_STALL_EN: store of 1 byte to 0x30000 while io_buffer_full=1 for 3 cycles → mem_wr stays 0 for those 3 cycles, byte is written on the 4th, then lsb_ready.
